branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Parametrised successor to the execute-stage PC-source selector.
- Adds a direct-mapped branch history table (2-bit saturating counters) and a tagged branch target buffer (BTB) that predict in Fetch.
- Resolves the full RV32I conditional set (beq/bne/blt/bge/bltu/bgeu) plus jal/jalr in Execute.
- Drives PC-source select and a mispredict/flush indication to the hazard unit.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, BHT/BTB depth; power of two, at least 4; IDX = log2(ENTRIES).
- INIT_CNT, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PCF  in  XLEN  fetch PC.
- PredTakenF  out  1  fetch prediction: BTB hit and counter[1]==1.
- PredTargetF  out  XLEN  BTB target; 0 when no hit.
- ValidE  in  1  Execute holds a real instruction, not a bubble.
- JumpE  in  2  00 none, 01 jal, 10 jalr.
- BranchE  in  1  conditional branch in Execute.
- Funct3E  in  3  branch type: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
- ZeroE, LtE, LtuE  in  1 each  ALU flags: equal, signed less-than, unsigned less-than.
- PredTakenE  in  1  PredTakenF carried down the pipeline.
- PCE  in  XLEN  PC of the Execute instruction.
- PCTargetE  in  XLEN  PCE + imm.
- PCSrcE  out  2  00 keep fetch stream, 01 PCTargetE, 10 ALU result (jalr), 11 PCE+4 (recovery).
- MispredictE  out  1  high when PCSrcE != 00; flushes D and E.
- BranchCnt, MispredCnt  out  32 each  performance counters (see Optional Feature).

Behaviour:
- Index = PC[IDX+1:2]; tag = PC[XLEN-1:IDX+2].
- Storage per entry: cnt[1:0], valid, tag, target[XLEN-1:0].
- Reset (async, rst_n low): cnt = INIT_CNT, valid = 0 for all entries; counters = 0. Outputs follow combinationally: PredTakenF = 0, PredTargetF = 0.
- Fetch lookup is combinational with zero latency.
  - hit = valid[idxF] && tag[idxF] == tagF.
  - PredTakenF = hit && cnt[idxF][1].
  - PredTargetF = hit ? target[idxF] : 0.
- Branch condition: taken = beq Z; bne !Z; blt Lt; bge !Lt; bltu Ltu; bgeu !Ltu. Funct3 010 and 011 give not-taken.
- PCSrcE and MispredictE are combinational. When ValidE == 0, PCSrcE = 00 and MispredictE = 0. Otherwise, in priority order:
  - jalr: 10, always; jalr is never predicted.
  - jal or taken branch: 00 if PredTakenE, else 01.
  - not-taken branch with PredTakenE: 11.
  - otherwise: 00.
  - PredTakenE on a non-branch, non-jump instruction (stale alias): 11.
- Update on the rising clk edge when ValidE && (BranchE || JumpE == 01). jalr and non-branch instructions do not update.
  - BHT: taken increments cnt, saturating at 11; not-taken decrements, saturating at 00.
  - jal: forces cnt = 11.
  - BTB: on taken, write valid = 1, tag = tagE, target = PCTargetE. Not-taken leaves the BTB unchanged.
  - Tag miss on update: the entry is replaced; the counter restarts at 10 if taken, else INIT_CNT.
- Same-cycle read and write to the same index: Fetch sees the pre-update value (no bypass).
- Reset asserted mid-operation clears state immediately; any in-flight update is dropped.

Optional Feature:
- Macro: BRANCH_PERF_EN.
- Defined:
  - BranchCnt increments on every update-qualifying cycle.
  - MispredCnt increments on every cycle with MispredictE == 1.
  - Both are 32-bit, wrap at 2^32-1 -> 0, and are cleared by rst_n.
- Undefined: both ports are tied to 0; no counter flops exist.

Test Plan:
- Reset, then PCF=0x100 -> PredTakenF=0, PredTargetF=0; ValidE=1 jalr -> PCSrcE=10, MispredictE=1.
- beq at PCE=0x100, ZeroE=1, PredTakenE=0, PCTargetE=0x80 -> PCSrcE=01; next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x80.
- Same branch resolved taken 3 times, then not-taken with PredTakenE=1 -> PCSrcE=11; counter 11->10, so PredTakenF stays 1.
- bltu with LtuE=1, LtE=0, PredTakenE=1 -> PCSrcE=00, MispredictE=0; bge with LtE=1 -> not-taken.
- Alias (ENTRIES=64): PC 0x100 and 0x200 share index 0 -> 0x200 taken evicts; PCF=0x100 -> PredTakenF=0.
- BRANCH_PERF_EN: 10 branches with 3 mispredicts -> BranchCnt=10, MispredCnt=3; rst_n pulse mid-run -> both 0; ValidE=0 cycles do not count.

Source files
------------

// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Fetch-side direction/target prediction (direct-mapped BHT of 2-bit
//   saturating counters plus a tagged BTB) and Execute-side resolution of
//   the RV32I conditional branches, jal and jalr.
//   Optional performance counters are built when BRANCH_PERF_EN is defined;
//   otherwise BranchCnt/MispredCnt are tied to zero and no counter flops exist.
//   Prediction handshake: there is no valid/ready pair here; PredTakenF is
//   carried by the pipeline into PredTakenE, and MispredictE is a
//   single-cycle flush request that the hazard unit must act on in the same
//   cycle it is high.

module branch_predict_unit #(
  parameter int         XLEN     = 32,
  parameter int         ENTRIES  = 64,
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  // Fetch
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  // Execute
  input  logic            ValidE,
  input  logic [1:0]      JumpE,
  input  logic            BranchE,
  input  logic [2:0]      Funct3E,
  input  logic            ZeroE,
  input  logic            LtE,
  input  logic            LtuE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [1:0]      PCSrcE,
  output logic            MispredictE,
  // Performance counters
  output logic [31:0]     BranchCnt,
  output logic [31:0]     MispredCnt
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  // Prediction tables, one slot per index
  logic [1:0]         cntMem    [ENTRIES];
  logic [ENTRIES-1:0] validMem;
  logic [TAGW-1:0]    tagMem    [ENTRIES];
  logic [XLEN-1:0]    targetMem [ENTRIES];

  logic [IDX-1:0]  idxF;
  logic [TAGW-1:0] tagF;
  logic            hitF;

  logic [IDX-1:0]  idxE;
  logic [TAGW-1:0] tagE;
  logic            hitE;

  logic            isJal;
  logic            isJalr;
  logic            brCond;
  logic            resolvedTaken;
  logic            updateE;
  logic [1:0]      nextCnt;
  logic [1:0]      pcSrc;

  // Instruction-alignment bits never take part in indexing or tagging
  logic unusedPcBits;
  assign unusedPcBits = ^{PCF[1:0], PCE[1:0]};

  assign idxF = PCF[IDX+1:2];
  assign tagF = PCF[XLEN-1:IDX+2];
  assign idxE = PCE[IDX+1:2];
  assign tagE = PCE[XLEN-1:IDX+2];

  // Zero-latency fetch lookup; reads the table state before this cycle's update
  assign hitF        = validMem[idxF] && (tagMem[idxF] == tagF);
  assign PredTakenF  = hitF && cntMem[idxF][1];
  assign PredTargetF = hitF ? targetMem[idxF] : '0;

  assign isJal  = (JumpE == 2'b01);
  assign isJalr = (JumpE == 2'b10);

  // Conditional-branch outcome from the ALU flags
  always_comb begin
    brCond = 1'b0;
    case (Funct3E)
      3'b000:  brCond = ZeroE;
      3'b001:  brCond = !ZeroE;
      3'b100:  brCond = LtE;
      3'b101:  brCond = !LtE;
      3'b110:  brCond = LtuE;
      3'b111:  brCond = !LtuE;
      default: brCond = 1'b0;
    endcase
  end

  assign resolvedTaken = isJal || (BranchE && brCond);

  // PC-source select: redirect only when the fetched stream was wrong
  always_comb begin
    pcSrc = 2'b00;
    if (ValidE) begin
      if (isJalr) begin
        pcSrc = 2'b10;
      end else if (resolvedTaken) begin
        pcSrc = PredTakenE ? 2'b00 : 2'b01;
      end else if (PredTakenE) begin
        // Not-taken branch, or a stale BTB alias on a non-control instruction
        pcSrc = 2'b11;
      end
    end
  end

  assign PCSrcE      = pcSrc;
  assign MispredictE = (pcSrc != 2'b00);

  // Only conditional branches and jal train the tables; jalr never does
  assign updateE = ValidE && !isJalr && (BranchE || isJal);
  assign hitE    = validMem[idxE] && (tagMem[idxE] == tagE);

  // Next counter value for the Execute index
  always_comb begin
    nextCnt = cntMem[idxE];
    if (isJal) begin
      nextCnt = 2'b11;
    end else if (!hitE) begin
      nextCnt = resolvedTaken ? 2'b10 : INIT_CNT;
    end else if (resolvedTaken) begin
      nextCnt = (cntMem[idxE] == 2'b11) ? 2'b11 : cntMem[idxE] + 2'b01;
    end else begin
      nextCnt = (cntMem[idxE] == 2'b00) ? 2'b00 : cntMem[idxE] - 2'b01;
    end
  end

  // Table update; reset wipes every entry and drops any pending write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validMem <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cntMem[i]    <= INIT_CNT;
        tagMem[i]    <= '0;
        targetMem[i] <= '0;
      end
    end else if (updateE) begin
      cntMem[idxE] <= nextCnt;
      if (resolvedTaken) begin
        validMem[idxE]  <= 1'b1;
        tagMem[idxE]    <= tagE;
        targetMem[idxE] <= PCTargetE;
      end
    end
  end

`ifdef BRANCH_PERF_EN
  logic [31:0] branchCntQ;
  logic [31:0] mispredCntQ;

  // Event counters; natural 32-bit wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branchCntQ  <= '0;
      mispredCntQ <= '0;
    end else begin
      if (updateE)     branchCntQ  <= branchCntQ + 32'd1;
      if (MispredictE) mispredCntQ <= mispredCntQ + 32'd1;
    end
  end

  assign BranchCnt  = branchCntQ;
  assign MispredCnt = mispredCntQ;
`else
  assign BranchCnt  = '0;
  assign MispredCnt = '0;
`endif

endmodule
